// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - two-requester writeback arbiter for the register file write port
//
// Purpose:
//    Shares the register file's single write port between the ALU result path
//    (requester A) and the load/memory return path (requester B). One request
//    is granted per cycle. The winner is registered onto write_en/write_reg/
//    write_data, which drive the register file directly. Writes to register 0
//    are accepted but never enabled. A saturating counter records every cycle
//    in which a valid request was denied.
//
// Configuration macro: WB_ROUND_ROBIN_EN
//    defined   : round-robin on conflict (requester not granted last wins)
//    undefined : fixed priority A > B, B forced to win after MAX_WAIT denials
//
// Parameters:
//    MAX_WAIT     consecutive denied cycles B tolerates before it is forced to win
//    STALL_W      width of stall_count
//
// Ports:
//    clk          in   rising-edge clock
//    reset        in   asynchronous active-high reset
//    a_valid      in   A has a write pending
//    a_ready      out  A granted this cycle (combinational)
//    a_reg        in   A destination register
//    a_data       in   A write data
//    b_valid      in   B has a write pending
//    b_ready      out  B granted this cycle (combinational)
//    b_reg        in   B destination register
//    b_data       in   B write data
//    write_en     out  register file write enable (registered)
//    write_reg    out  register file write address (registered)
//    write_data   out  register file write data (registered)
//    stall_count  out  saturating count of cycles with a denied valid request

module reg_wb_arbiter #(
   parameter int MAX_WAIT = 3,
   parameter int STALL_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [4:0]         a_reg,
   input  logic [31:0]        a_data,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [4:0]         b_reg,
   input  logic [31:0]        b_data,
   output logic               write_en,
   output logic [4:0]         write_reg,
   output logic [31:0]        write_data,
   output logic [STALL_W-1:0] stall_count
);

   // Registered write port and performance counter.
   logic               write_en_q,    write_en_d;
   logic [4:0]         write_reg_q,   write_reg_d;
   logic [31:0]        write_data_q,  write_data_d;
   logic [STALL_W-1:0] stall_count_q, stall_count_d;

`ifdef WB_ROUND_ROBIN_EN
   // Set when the most recent grant went to B; resets to B so A wins the
   // first conflict after reset.
   logic               last_b_q,      last_b_d;
`else
   // Width covers 0..MAX_WAIT; at least one bit so MAX_WAIT = 0 still builds.
   localparam int              WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0]  wait_q,        wait_d;
`endif

   logic               grant_a;
   logic               grant_b;
   logic               stalled;
   logic [4:0]         sel_reg;
   logic [31:0]        sel_data;

   // ------------------------------------------------------------------
   // Grant decision (combinational, same cycle as the valids)
   // ------------------------------------------------------------------
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;

      if (a_valid && b_valid) begin
`ifdef WB_ROUND_ROBIN_EN
         if (last_b_q) begin
            grant_a = 1'b1;
         end else begin
            grant_b = 1'b1;
         end
`else
         // A normally wins; B is forced through once it has waited MAX_WAIT
         // consecutive denied cycles so loads cannot starve behind ALU traffic.
         if (wait_q == WAIT_MAX) begin
            grant_b = 1'b1;
         end else begin
            grant_a = 1'b1;
         end
`endif
      end else if (a_valid) begin
         grant_a = 1'b1;
      end else if (b_valid) begin
         grant_b = 1'b1;
      end

      // Nothing may retire while reset is held: the request would be lost
      // because the output flops are being cleared.
      if (reset) begin
         grant_a = 1'b0;
         grant_b = 1'b0;
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // A valid requester that did not receive the grant this cycle.
   assign stalled = (a_valid && !grant_a) || (b_valid && !grant_b);

   assign sel_reg  = grant_b ? b_reg  : a_reg;
   assign sel_data = grant_b ? b_data : a_data;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      write_en_d    = 1'b0;
      write_reg_d   = write_reg_q;
      write_data_d  = write_data_q;
      stall_count_d = stall_count_q;

      if (grant_a || grant_b) begin
         // Register 0 writes retire the requester but never enable the port;
         // address and data still update so the port reflects the last grant.
         write_en_d   = (sel_reg != 5'd0);
         write_reg_d  = sel_reg;
         write_data_d = sel_data;
      end

      if (stalled && (stall_count_q != {STALL_W{1'b1}})) begin
         stall_count_d = stall_count_q + STALL_W'(1);
      end
   end

`ifdef WB_ROUND_ROBIN_EN
   always_comb begin
      last_b_d = last_b_q;
      if (grant_a) begin
         last_b_d = 1'b0;
      end else if (grant_b) begin
         last_b_d = 1'b1;
      end
   end
`else
   always_comb begin
      wait_d = wait_q;
      if (grant_b) begin
         wait_d = '0;
      end else if (b_valid && (wait_q != WAIT_MAX)) begin
         // Cannot pass WAIT_MAX in practice since B then wins the next
         // conflict; the guard just keeps the counter from wrapping.
         wait_d = wait_q + WAIT_W'(1);
      end
   end
`endif

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_en_q    <= 1'b0;
         write_reg_q   <= 5'd0;
         write_data_q  <= 32'd0;
         stall_count_q <= '0;
`ifdef WB_ROUND_ROBIN_EN
         last_b_q      <= 1'b1;
`else
         wait_q        <= '0;
`endif
      end else begin
         write_en_q    <= write_en_d;
         write_reg_q   <= write_reg_d;
         write_data_q  <= write_data_d;
         stall_count_q <= stall_count_d;
`ifdef WB_ROUND_ROBIN_EN
         last_b_q      <= last_b_d;
`else
         wait_q        <= wait_d;
`endif
      end
   end

   assign write_en    = write_en_q;
   assign write_reg   = write_reg_q;
   assign write_data  = write_data_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter

module tb_reg_wb_arbiter;

   localparam int MAX_WAIT = 3;
   localparam int STALL_W  = 16;

   logic               clk;
   logic               reset;
   logic               a_valid;
   logic               a_ready;
   logic [4:0]         a_reg;
   logic [31:0]        a_data;
   logic               b_valid;
   logic               b_ready;
   logic [4:0]         b_reg;
   logic [31:0]        b_data;
   logic               write_en;
   logic [4:0]         write_reg;
   logic [31:0]        write_data;
   logic [STALL_W-1:0] stall_count;

   reg_wb_arbiter #(
      .MAX_WAIT (MAX_WAIT),
      .STALL_W  (STALL_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_reg       (a_reg),
      .a_data      (a_data),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_reg       (b_reg),
      .b_data      (b_data),
      .write_en    (write_en),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file driven by the DUT write port.
   logic [31:0] rf [32];
   always @(posedge clk) begin
      if (write_en) rf[write_reg] <= write_data;
   end

   typedef struct {
      logic        en;
      logic [4:0]  rg;
      logic [31:0] data;
      logic [15:0] stall;
      string       tag;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int          m_wait;
   logic        m_last_b;
   logic [15:0] m_stall;
   logic [4:0]  m_reg;
   logic [31:0] m_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wait   = 0;
      m_last_b = 1'b1;
      m_stall  = 16'd0;
      m_reg    = 5'd0;
      m_data   = 32'd0;
      exp_q.delete();
   endtask

   // Drive one cycle of requests, check ready, predict and check the registered result.
   task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input string tag);
      logic ga, gb;
      exp_t e;
      @(negedge clk);
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      ga = 1'b0;
      gb = 1'b0;
      if (av && bv) begin
`ifdef WB_ROUND_ROBIN_EN
         if (m_last_b) ga = 1'b1; else gb = 1'b1;
`else
         if (m_wait == MAX_WAIT) gb = 1'b1; else ga = 1'b1;
`endif
      end else if (av) begin
         ga = 1'b1;
      end else if (bv) begin
         gb = 1'b1;
      end
      #1;
      chk({tag, " a_ready"}, 32'(a_ready), 32'(ga));
      chk({tag, " b_ready"}, 32'(b_ready), 32'(gb));

      e.en = 1'b0;
      if (ga) begin
         m_reg = ar; m_data = ad; e.en = (ar != 5'd0); m_last_b = 1'b0;
      end else if (gb) begin
         m_reg = br; m_data = bd; e.en = (br != 5'd0); m_last_b = 1'b1;
      end
      if (gb) m_wait = 0;
      else if (bv && m_wait < MAX_WAIT) m_wait++;
      if (((av && !ga) || (bv && !gb)) && m_stall != 16'hFFFF) m_stall++;
      e.rg    = m_reg;
      e.data  = m_data;
      e.stall = m_stall;
      e.tag   = tag;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, " write_en"},    32'(write_en),    32'(e.en));
         chk({e.tag, " write_reg"},   32'(write_reg),   32'(e.rg));
         chk({e.tag, " write_data"},  write_data,       e.data);
         chk({e.tag, " stall_count"}, 32'(stall_count), 32'(e.stall));
      end
   endtask

   initial begin
      reset   = 1'b1;
      a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
      b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
      model_reset();

      // Reset state, with a request presented during reset.
      repeat (2) @(negedge clk);
      a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h5555_0004;
      b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h5555_0009;
      #1;
      chk("rst a_ready",     32'(a_ready),     32'd0);
      chk("rst b_ready",     32'(b_ready),     32'd0);
      chk("rst write_en",    32'(write_en),    32'd0);
      chk("rst write_reg",   32'(write_reg),   32'd0);
      chk("rst write_data",  write_data,       32'd0);
      chk("rst stall_count", 32'(stall_count), 32'd0);
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      reset = 1'b0;

      // Single requester A.
      step(1'b1, 5'd10, 32'h1234_ABCD, 1'b0, 5'd0, 32'd0, "single_a");
      step(1'b0, 5'd0,  32'd0,         1'b0, 5'd0, 32'd0, "idle_after_a");

      // Single requester B, then a write to register 0.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCAFE_0012, "single_b");
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0,  32'hFFFF_FFFF, "zero_b");
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0,  32'd0,         "idle_after_zero");

      // Continuous conflict: A on r5, B on r6.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 5'd5, 32'hAAAA_0005, 1'b1, 5'd6, 32'hBBBB_0006, $sformatf("conflict%0d", i));
      end
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "idle_after_conflict");

      // Same-register collision on r7: A retires first, then B.
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, "collide_both");
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2, "collide_b");
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "idle_after_collide");
      chk("collide rf7", rf[7], 32'h2);
      chk("single rf10", rf[10], 32'h1234_ABCD);

      // Reset asserted asynchronously while write_en is high.
      step(1'b1, 5'd3, 32'hDEAD_0003, 1'b0, 5'd0, 32'd0, "pre_reset");
      #2;
      reset = 1'b1;
      #1;
      chk("midrst write_en",    32'(write_en),    32'd0);
      chk("midrst write_reg",   32'(write_reg),   32'd0);
      chk("midrst write_data",  write_data,       32'd0);
      chk("midrst stall_count", 32'(stall_count), 32'd0);
      chk("midrst a_ready",     32'(a_ready),     32'd0);
      chk("midrst b_ready",     32'(b_ready),     32'd0);
      @(negedge clk);
      a_valid = 1'b0;
      reset = 1'b0;
      model_reset();

      // Recovery after reset: conflict starts fresh.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 5'd20, 32'h2020_0000 + i, 1'b1, 5'd21, 32'h2121_0021, $sformatf("post_rst%0d", i));
      end
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, "final_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

- Shares the register file's single write port between two writeback requesters:
  - A = ALU result path.
  - B = load/memory return path.
- Arbitrates one request per cycle and registers the winner onto `write_en`/`write_reg`/`write_data`, which drive the register file directly.
- Drops writes to `$zero` and keeps a saturating count of denied-request cycles for performance debug.

## Interface

Parameters:
- `MAX_WAIT`, default 3: consecutive cycles B may be denied before it is forced to win (fixed-priority mode only).
- `STALL_W`, default 16: width of the stall counter.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `a_valid`  input  1  requester A has a write pending.
- `a_ready`  output  1  A accepted this cycle when `a_valid && a_ready`.
- `a_reg`  input  5  destination register for A.
- `a_data`  input  32  write data for A.
- `b_valid`, `b_ready`, `b_reg`, `b_data`: as for A, for requester B.
- `write_en`  output  1  register-file write enable.
- `write_reg`  output  5  register-file write address.
- `write_data`  output  32  register-file write data.
- `stall_count`  output  STALL_W  cycles in which at least one valid request was denied; saturates at all-ones.

## Operation

- Each requester holds `*_reg` and `*_data` stable while `*_valid` is high and not yet accepted.
- Exactly zero or one grant per cycle.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Neither valid: no grant.
  - Both valid: see the arbitration rule in Configuration.
- `*_ready` is combinational from the valids and arbiter state. It is asserted only for the granted requester.
- A request is accepted on the rising edge where `valid && ready`. On that edge:
  - `write_reg` ← granted address.
  - `write_data` ← granted data.
  - `write_en` ← 1, unless the granted address is 0.
- Writes to register 0 are accepted (ready = 1, so the requester retires) but produce `write_en` = 0. `write_reg`/`write_data` still update.
- With no grant on an edge, `write_en` ← 0; `write_reg`/`write_data` hold their previous values.
- `stall_count` increments by 1 on each edge where a valid requester was not granted. It holds at 2^STALL_W−1.
- Same-register collision: when A and B both target register r, they retire in grant order. The later write wins in the register file. No merging.
- Reset, asynchronous:
  - `write_en` = 0, `write_reg` = 0, `write_data` = 0, `stall_count` = 0.
  - Wait counter = 0; last-grant pointer = B.
  - A request in flight when reset asserts is discarded; its requester must re-present it.

## Timing

- Latency: accept at edge N → `write_en` high during cycle N..N+1 → register file commits at edge N+1.
- Throughput: one write per cycle sustained.
- `*_ready` is valid in the same cycle as `*_valid`, with no registered delay.
- Outputs are registered. No combinational path from requester inputs to `write_*`.
- During reset assertion: `a_ready` = `b_ready` = 0, and all outputs are at reset values.

## Configuration

Macro `WB_ROUND_ROBIN_EN`.

- Defined: round-robin arbitration on conflict.
  - The requester not granted last wins; the last-grant pointer updates on every grant.
  - The wait counter and `MAX_WAIT` are unused; the wait counter is not compiled.
- Undefined: fixed priority A > B, with a starvation guard.
  - The wait counter increments each cycle B is valid and denied.
  - It resets to 0 when B is granted.
  - When it equals `MAX_WAIT`, B wins the next conflict.
  - The last-grant pointer is unused.

## Test plan

1. Reset mid-stream: assert `reset` asynchronously while `write_en` = 1 → all outputs 0 immediately, both `*_ready` = 0, `stall_count` = 0.
2. Single requester: A writes `a_reg`=10, `a_data`=32'h1234ABCD → `a_ready` = 1 same cycle; `write_en` = 1, `write_reg` = 10, `write_data` = 32'h1234ABCD for exactly one cycle after the edge.
3. Zero register: B writes `b_reg`=0, `b_data`=32'hFFFFFFFF → `b_ready` = 1; `write_en` stays 0.
4. Conflict, fixed priority (macro off, `MAX_WAIT`=3): A and B valid continuously with regs 5 and 6.
   - Grants A,A,A,B,A,A,A,B…
   - `stall_count` +1 every cycle.
5. Conflict, round-robin (macro on): same stimulus → grants A,B,A,B…
6. Same-register collision: A (r7, 32'h1) and B (r7, 32'h2) valid together, fixed priority → writes 32'h1 then 32'h2 on consecutive cycles; the register file holds 32'h2.
